collision_ctrl: RTL and testbench
=================================

COLLISION_CTRL -- requirements
Module: collision_ctrl

Interface
REQ-001 Parameter OBJ_W, default 64, obstacle/pickup width in pixels.
REQ-002 Parameter OBJ_H, default 64, obstacle/pickup height in pixels.
REQ-003 Parameter OIL_FRAMES, default 90, frames the car stays oiled.
REQ-004 Parameter INVULN_FRAMES, default 120, post-crash invulnerability frames.
REQ-005 Parameter LIVES_START, default 3, lives at reset (range 1-3).
REQ-006 frame_clk  in  1  frame-rate clock; all state updates on its rising edge.
REQ-007 Reset  in  1  asynchronous, active-high reset.
REQ-008 menuLive  in  1  menu shown; block frozen while high.
REQ-009 CarX, CarY, CarW, CarH  in  11 each  player car box: X = horizontal centre, Y = top edge.
REQ-010 OilX, OilY  in  11 each  oil slick position, same convention as the car; OilValid  in  1.
REQ-011 NosX, NosY  in  11 each  NOS canister position; NosValid  in  1.
REQ-012 BarX, BarY  in  11 each  barrier position; BarValid  in  1.
REQ-013 nosLoadedIn  in  1  car ready to accept a NOS charge (0 while boosting).
REQ-014 noShift  out  1  lane changes inhibited (car oiled).
REQ-015 nosLoadedOut  out  1  NOS charge held and available to car.
REQ-016 lives  out  2  remaining lives.
REQ-017 invuln  out  1  post-crash invulnerability (sprite flashing).
REQ-018 game_over  out  1  sticky end-of-game flag.
REQ-019 oil_hit, nos_taken, bar_hit  out  1 each  single-frame pulses telling the spawner to retire the object.

Function
REQ-020 Overlap SHALL be strict box intersection: car [CarX-CarW/2, CarX+CarW/2) x [CarY, CarY+CarH) against object [X-OBJ_W/2, X+OBJ_W/2) x [Y, Y+OBJ_H); arithmetic SHALL be 12-bit signed, so negative left edges compare correctly; an object with Valid=0 never overlaps.
REQ-021 The block SHALL implement the states PLAY, OILED, INVULN and OVER, with an 8-bit frame timer.
REQ-022 In PLAY or OILED, a barrier overlap SHALL pulse bar_hit and decrement lives. The next state SHALL be OVER if lives was 1; otherwise it SHALL be INVULN with timer=INVULN_FRAMES.
REQ-023 In PLAY, an oil overlap with no barrier overlap SHALL pulse oil_hit and enter OILED with timer=OIL_FRAMES.
REQ-024 In OILED, an oil overlap SHALL pulse oil_hit and reload timer=OIL_FRAMES; otherwise the timer decrements, and on a tick where timer==0 the state returns to PLAY.
REQ-025 In INVULN, barrier and oil overlaps SHALL be ignored with no pulses. The timer decrements each tick, and on a tick where timer==0 the state returns to PLAY.
REQ-026 OVER SHALL be absorbing until Reset; no pulses, no NOS pickup, and lives holds at 0.
REQ-027 Simultaneous barrier and oil overlap SHALL be resolved as barrier only.
REQ-028 NOS pickup is independent of the state machine, except in OVER. It occurs when NosValid overlaps, nosLoadedIn=1 and nosLoadedOut=0: nos_taken pulses and nosLoadedOut sets next tick.
REQ-029 With NOS overlap while nosLoadedOut=1 or nosLoadedIn=0, there SHALL be no pulse and the canister stays.
REQ-030 nosLoadedOut SHALL clear on any tick where nosLoadedIn=0 (charge consumed); clear SHALL take priority over set.
REQ-031 Registered outputs: noShift=(state==OILED); invuln=(state==INVULN); game_over=(state==OVER); latency of one frame_clk from overlap to outputs.
REQ-032 While menuLive=1, all state, timer, lives and nosLoadedOut SHALL hold, and all pulses SHALL be 0.
REQ-033 Pulses SHALL be high for exactly one tick per event.

Reset
REQ-034 Reset SHALL force, asynchronously, state=PLAY, timer=0, lives=LIVES_START, and noShift=nosLoadedOut=invuln=game_over=0 with all pulses 0, including mid-OILED, mid-INVULN and OVER.

Verification
REQ-035 Car (320,300,64,130), Oil at (320,380) valid -> next tick oil_hit=1 for one tick, noShift=1; noShift stays high for 91 ticks with the car clear, then 0.
REQ-036 Lives=3, barrier overlap -> bar_hit pulse, lives=2, invuln=1 for 121 ticks; a barrier overlap during INVULN gives no bar_hit and lives stays 2.
REQ-037 Lives=1, barrier overlap while OILED -> lives=0, game_over=1, noShift=0; further overlaps give no pulses until Reset restores lives=3.
REQ-038 Barrier and oil both overlapping in PLAY -> only bar_hit, state INVULN, noShift=0.
REQ-039 NOS overlap with nosLoadedIn=1 -> nos_taken pulse, nosLoadedOut=1; then nosLoadedIn=0 -> nosLoadedOut=0 next tick; NOS overlap with nosLoadedIn=0 -> no pulse.
REQ-040 menuLive=1 during OILED with timer=50 for 20 ticks -> timer, noShift and lives unchanged; Reset asserted mid-INVULN -> all outputs at reset values immediately, without waiting for frame_clk.

Source files
------------

// File: rtl/collision_ctrl_if.sv
// Bundle of game-object positions, car handshake and collision results
// shared between the game logic (master) and collision_ctrl (slave).
interface collision_ctrl_if;
    logic        menuLive;
    logic [10:0] CarX, CarY, CarW, CarH;
    logic [10:0] OilX, OilY;
    logic        OilValid;
    logic [10:0] NosX, NosY;
    logic        NosValid;
    logic [10:0] BarX, BarY;
    logic        BarValid;
    logic        nosLoadedIn;
    logic        noShift;
    logic        nosLoadedOut;
    logic [1:0]  lives;
    logic        invuln;
    logic        game_over;
    logic        oil_hit;
    logic        nos_taken;
    logic        bar_hit;

    modport master (
        output menuLive, CarX, CarY, CarW, CarH, OilX, OilY, OilValid,
               NosX, NosY, NosValid, BarX, BarY, BarValid, nosLoadedIn,
        input  noShift, nosLoadedOut, lives, invuln, game_over,
               oil_hit, nos_taken, bar_hit
    );

    modport slave (
        input  menuLive, CarX, CarY, CarW, CarH, OilX, OilY, OilValid,
               NosX, NosY, NosValid, BarX, BarY, BarValid, nosLoadedIn,
        output noShift, nosLoadedOut, lives, invuln, game_over,
               oil_hit, nos_taken, bar_hit
    );
endinterface

// File: rtl/collision_ctrl.sv
// Car-versus-object collision handling: oil slicks, barriers (lives), NOS pickup.
// state  | meaning
// PLAY   | normal driving, all collisions live
// OILED  | car skidding, lane changes inhibited until timer expires
// INVULN | post-crash grace period, barrier and oil ignored
// OVER   | no lives left, absorbing until Reset
module collision_ctrl #(
    parameter int OBJ_W         = 64,
    parameter int OBJ_H         = 64,
    parameter int OIL_FRAMES    = 90,
    parameter int INVULN_FRAMES = 120,
    parameter int LIVES_START   = 3
) (
    input logic frame_clk,
    input logic Reset,
    collision_ctrl_if.slave bus
);

    typedef enum logic [1:0] {PLAY, OILED, INVULN, OVER} state_t;

    localparam logic [11:0] HALF_W     = 12'(OBJ_W / 2);
    localparam logic [11:0] FULL_H     = 12'(OBJ_H);
    localparam logic [7:0]  OIL_LOAD   = 8'(OIL_FRAMES);
    localparam logic [7:0]  INV_LOAD   = 8'(INVULN_FRAMES);
    localparam logic [1:0]  LIVES_INIT = 2'(LIVES_START);

    state_t     state;
    logic [7:0] timer;
    logic [1:0] lives_q;
    logic       nos_loaded;
    logic       oil_pulse, nos_pulse, bar_pulse;
    logic       oil_ov, nos_ov, bar_ov;

    // Edges are 12-bit signed so a box hanging off the left of the screen still compares correctly.
    function automatic logic overlap(
        input logic [10:0] cx, cy, cw, ch, ox, oy,
        input logic        valid
    );
        logic signed [11:0] car_l, car_r, car_t, car_b;
        logic signed [11:0] obj_l, obj_r, obj_t, obj_b;
        car_l = {1'b0, cx} - {2'b0, cw[10:1]};
        car_r = {1'b0, cx} + {2'b0, cw[10:1]};
        car_t = {1'b0, cy};
        car_b = {1'b0, cy} + {1'b0, ch};
        obj_l = {1'b0, ox} - HALF_W;
        obj_r = {1'b0, ox} + HALF_W;
        obj_t = {1'b0, oy};
        obj_b = {1'b0, oy} + FULL_H;
        return valid && (car_l < obj_r) && (obj_l < car_r) &&
               (car_t < obj_b) && (obj_t < car_b);
    endfunction

    assign oil_ov = overlap(bus.CarX, bus.CarY, bus.CarW, bus.CarH, bus.OilX, bus.OilY, bus.OilValid);
    assign nos_ov = overlap(bus.CarX, bus.CarY, bus.CarW, bus.CarH, bus.NosX, bus.NosY, bus.NosValid);
    assign bar_ov = overlap(bus.CarX, bus.CarY, bus.CarW, bus.CarH, bus.BarX, bus.BarY, bus.BarValid);

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state      <= PLAY;
            timer      <= '0;
            lives_q    <= LIVES_INIT;
            nos_loaded <= 1'b0;
            oil_pulse  <= 1'b0;
            nos_pulse  <= 1'b0;
            bar_pulse  <= 1'b0;
        end else begin
            oil_pulse <= 1'b0;
            nos_pulse <= 1'b0;
            bar_pulse <= 1'b0;
            if (!bus.menuLive) begin
                // Consumption by the car wins over a pickup on the same tick.
                if (!bus.nosLoadedIn) begin
                    nos_loaded <= 1'b0;
                end else if (state != OVER && nos_ov && !nos_loaded) begin
                    nos_loaded <= 1'b1;
                    nos_pulse  <= 1'b1;
                end

                case (state)
                    PLAY, OILED: begin
                        if (bar_ov) begin
                            bar_pulse <= 1'b1;
                            lives_q   <= lives_q - 2'd1;
                            if (lives_q == 2'd1) begin
                                state <= OVER;
                                timer <= '0;
                            end else begin
                                state <= INVULN;
                                timer <= INV_LOAD;
                            end
                        end else if (oil_ov) begin
                            oil_pulse <= 1'b1;
                            state     <= OILED;
                            timer     <= OIL_LOAD;
                        end else if (state == OILED) begin
                            if (timer == 8'd0) state <= PLAY;
                            else               timer <= timer - 8'd1;
                        end
                    end
                    INVULN: begin
                        if (timer == 8'd0) state <= PLAY;
                        else               timer <= timer - 8'd1;
                    end
                    default: begin
                        state <= OVER;
                    end
                endcase
            end
        end
    end

    assign bus.noShift      = (state == OILED);
    assign bus.invuln       = (state == INVULN);
    assign bus.game_over    = (state == OVER);
    assign bus.lives        = lives_q;
    assign bus.nosLoadedOut = nos_loaded;
    assign bus.oil_hit      = oil_pulse;
    assign bus.nos_taken    = nos_pulse;
    assign bus.bar_hit      = bar_pulse;

endmodule

// File: tb/tb_collision_ctrl.sv
// Directed and randomized checks of collision_ctrl against a frames-remaining reference model.
module tb_collision_ctrl;
    localparam int OBJ_W = 64, OBJ_H = 64, OIL_F = 90, INV_F = 120, LIVES0 = 3;

    logic frame_clk = 1'b0;
    logic Reset     = 1'b0;
    collision_ctrl_if bus();

    collision_ctrl #(
        .OBJ_W(OBJ_W), .OBJ_H(OBJ_H), .OIL_FRAMES(OIL_F),
        .INVULN_FRAMES(INV_F), .LIVES_START(LIVES0)
    ) dut (
        .frame_clk(frame_clk),
        .Reset(Reset),
        .bus(bus)
    );

    always #5 frame_clk = ~frame_clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: effects expressed as "frames still to be shown" counters.
    int m_lives, m_oil_left, m_inv_left;
    bit m_over, m_nos, m_oil_hit, m_nos_hit, m_bar_hit;

    function automatic bit hits(int ox, int oy, bit valid);
        int cl, cr, ct, cb;
        cl = int'(bus.CarX) - int'(bus.CarW) / 2;
        cr = int'(bus.CarX) + int'(bus.CarW) / 2;
        ct = int'(bus.CarY);
        cb = int'(bus.CarY) + int'(bus.CarH);
        return valid && cl < ox + OBJ_W / 2 && ox - OBJ_W / 2 < cr && ct < oy + OBJ_H && oy < cb;
    endfunction

    task automatic model_reset();
        m_lives = LIVES0; m_oil_left = 0; m_inv_left = 0;
        m_over = 0; m_nos = 0; m_oil_hit = 0; m_nos_hit = 0; m_bar_hit = 0;
    endtask

    task automatic model_tick();
        bit bo, oo, no;
        m_oil_hit = 0; m_nos_hit = 0; m_bar_hit = 0;
        if (bus.menuLive) return;
        bo = hits(int'(bus.BarX), int'(bus.BarY), bus.BarValid);
        oo = hits(int'(bus.OilX), int'(bus.OilY), bus.OilValid);
        no = hits(int'(bus.NosX), int'(bus.NosY), bus.NosValid);
        if (!bus.nosLoadedIn) m_nos = 0;
        else if (!m_over && no && !m_nos) begin m_nos = 1; m_nos_hit = 1; end
        if (m_over) return;
        if (m_inv_left > 0) begin
            m_inv_left--;
        end else if (bo) begin
            m_bar_hit = 1;
            m_lives--;
            m_oil_left = 0;
            if (m_lives == 0) m_over = 1;
            else m_inv_left = INV_F + 1;
        end else if (oo) begin
            m_oil_hit = 1;
            m_oil_left = OIL_F + 1;
        end else if (m_oil_left > 0) begin
            m_oil_left--;
        end
    endtask

    task automatic chk(string tag, logic [1:0] obs, logic [1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("lives", bus.lives, 2'(m_lives));
        chk("noShift", {1'b0, bus.noShift}, {1'b0, m_oil_left > 0});
        chk("invuln", {1'b0, bus.invuln}, {1'b0, m_inv_left > 0});
        chk("game_over", {1'b0, bus.game_over}, {1'b0, m_over});
        chk("nosLoadedOut", {1'b0, bus.nosLoadedOut}, {1'b0, m_nos});
        chk("oil_hit", {1'b0, bus.oil_hit}, {1'b0, m_oil_hit});
        chk("nos_taken", {1'b0, bus.nos_taken}, {1'b0, m_nos_hit});
        chk("bar_hit", {1'b0, bus.bar_hit}, {1'b0, m_bar_hit});
    endtask

    task automatic step();
        model_tick();
        @(posedge frame_clk);
        #1;
        check_all();
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_objs();
        bus.OilValid = 0; bus.NosValid = 0; bus.BarValid = 0;
        bus.OilX = 1000; bus.OilY = 20; bus.NosX = 1000; bus.NosY = 20;
        bus.BarX = 1000; bus.BarY = 20;
    endtask

    task automatic do_reset();
        #2 Reset = 1'b1;
        #1;
        model_reset();
        check_all();
        #2 Reset = 1'b0;
    endtask

    int dxs[8] = '{0, 20, -40, 63, -63, 64, -64, 150};
    int dys[8] = '{0, 80, -63, -64, 129, 130, 40, 300};

    task automatic rand_obj(output logic [10:0] x, output logic [10:0] y, output logic v);
        int px, py;
        px = int'(bus.CarX) + dxs[$urandom_range(0, 7)];
        py = int'(bus.CarY) + dys[$urandom_range(0, 7)];
        x = 11'(px < 0 ? 0 : px);
        y = 11'(py < 0 ? 0 : py);
        v = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        bus.menuLive = 0; bus.nosLoadedIn = 1;
        bus.CarX = 320; bus.CarY = 300; bus.CarW = 64; bus.CarH = 130;
        clear_objs();
        model_reset();
        @(posedge frame_clk);
        #1;
        do_reset();

        // Oil slick: one pulse, then 91 oiled frames with the car clear.
        bus.OilX = 320; bus.OilY = 380; bus.OilValid = 1;
        step();
        clear_objs();
        steps(95);

        // Barrier crash, then barrier overlaps ignored during invulnerability.
        bus.BarX = 320; bus.BarY = 300; bus.BarValid = 1;
        step();
        steps(30);
        clear_objs();
        steps(95);

        // Second crash to reach one life, then oil, then final crash while oiled.
        bus.BarX = 300; bus.BarY = 350; bus.BarValid = 1;
        step();
        clear_objs();
        steps(125);
        bus.OilX = 320; bus.OilY = 300; bus.OilValid = 1;
        step();
        clear_objs();
        steps(3);
        bus.BarX = 320; bus.BarY = 300; bus.BarValid = 1;
        bus.OilValid = 1; bus.NosX = 320; bus.NosY = 300; bus.NosValid = 1;
        steps(6);
        do_reset();

        // Barrier and oil together: barrier only.
        bus.OilX = 330; bus.OilY = 320; bus.OilValid = 1;
        bus.BarX = 310; bus.BarY = 340; bus.BarValid = 1;
        step();
        clear_objs();
        steps(10);
        do_reset();

        // NOS pickup, consumption, blocked pickup; plus exact-touching edges.
        bus.NosX = 320; bus.NosY = 300; bus.NosValid = 1;
        steps(3);
        bus.nosLoadedIn = 0;
        steps(3);
        bus.nosLoadedIn = 1;
        bus.NosX = 320 - 64; step();
        bus.NosX = 320 + 64; step();
        bus.NosX = 320; bus.NosY = 300 + 130; step();
        bus.NosY = 300 - 64; step();
        bus.NosY = 300 - 63; step();
        clear_objs();
        bus.nosLoadedIn = 0; step();
        bus.nosLoadedIn = 1;

        // Car hanging off the left edge still collides.
        bus.CarX = 10;
        bus.OilX = 0; bus.OilY = 300; bus.OilValid = 1;
        step();
        clear_objs();
        steps(40);
        bus.menuLive = 1;
        bus.OilX = 0; bus.OilY = 300; bus.OilValid = 1;
        bus.BarX = 0; bus.BarY = 300; bus.BarValid = 1;
        steps(20);
        bus.menuLive = 0;
        clear_objs();
        steps(60);
        bus.CarX = 320;

        // Asynchronous reset in the middle of invulnerability.
        bus.BarX = 320; bus.BarY = 300; bus.BarValid = 1;
        step();
        clear_objs();
        steps(10);
        do_reset();

        // Randomized play.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) bus.CarX = 11'($urandom_range(0, 400));
            rand_obj(bus.OilX, bus.OilY, bus.OilValid);
            rand_obj(bus.NosX, bus.NosY, bus.NosValid);
            rand_obj(bus.BarX, bus.BarY, bus.BarValid);
            if ($urandom_range(0, 9) != 0) bus.OilValid = 0;
            if ($urandom_range(0, 29) != 0) bus.BarValid = 0;
            bus.nosLoadedIn = ($urandom_range(0, 4) != 0);
            bus.menuLive    = ($urandom_range(0, 19) == 0);
            step();
            if (m_over && $urandom_range(0, 30) == 0) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
